ps2_host_tx: RTL

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable) from the game controller to the keyboard.
- It is the transmit end of the same PS/2 link whose receive side delivers scancodes to the Tetris input logic.
- Drives the open-collector PS/2 clock and data lines via low-active output enables, follows the device-generated clock, and reports ACK or error.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync_edge.sv | 33 +++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 link definitions: host transmitter states, frame geometry and
// the command bytes exchanged with the keyboard.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_state_t;

    localparam int FRAME_LEN = 10;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // {stop, odd parity, data}; shifted out LSB first after the start bit.
    function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchroniser for one asynchronous PS/2 line, with a one-cycle
// falling-edge strobe on the synchronised value.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fe
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign fe   = prev_q & ~dout;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts a
// command byte out on the device clock and reports the device ACK or an error.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, ready to accept a byte
// INHIBIT   | hold PS/2 clock low for INHIBIT_CYCLES
// REQ       | single cycle: clock still low, data pulled low (start bit)
// DATA      | clock released; put next frame bit on each device falling edge
// ACK       | sample the device ACK bit on the next falling edge
// WAIT_IDLE | wait for both lines high, then pulse tx_done
// ERR       | lines released, pulse tx_err
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_LEN - 1);

    ps2_state_t             state_q, state_d;
    logic [INH_W-1:0]       inh_q, inh_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic [3:0]             bit_q, bit_d;
    logic [FRAME_LEN-1:0]   frame_q, frame_d;
    logic                   drv_q, drv_d;

    logic clk_sync, clk_fe;
    logic data_sync, data_fe_unused;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk_in),
        .dout  (clk_sync),
        .fe    (clk_fe)
    );

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_data_in),
        .dout  (data_sync),
        .fe    (data_fe_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            inh_q   <= '0;
            to_q    <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inh_d;
            to_q    <= to_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            drv_q   <= drv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inh_d   = inh_q;
        to_d    = to_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        drv_d   = drv_q;
        tx_done = 1'b0;
        tx_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    frame_d = make_frame(tx_data);
                    inh_d   = INH_LOAD;
                    bit_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == '0) begin
                    drv_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    inh_d = inh_q - INH_W'(1);
                end
            end
            REQ: begin
                bit_d   = '0;
                to_d    = TO_LOAD;
                state_d = DATA;
            end
            // Timeout wins over a falling edge in the same cycle.
            DATA: begin
                if (to_q == '0) begin
                    drv_d   = 1'b0;
                    state_d = ERR;
                end else begin
                    to_d = to_q - TO_W'(1);
                    if (clk_fe) begin
                        drv_d = ~frame_q[bit_q];
                        bit_d = bit_q + 4'd1;
                        if (bit_q == LAST_BIT) begin
                            state_d = ACK;
                        end
                    end
                end
            end
            ACK: begin
                if (to_q == '0) begin
                    drv_d   = 1'b0;
                    state_d = ERR;
                end else begin
                    to_d = to_q - TO_W'(1);
                    if (clk_fe) begin
                        state_d = data_sync ? ERR : WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (to_q == '0) begin
                    drv_d   = 1'b0;
                    state_d = ERR;
                end else begin
                    to_d = to_q - TO_W'(1);
                    if (clk_sync && data_sync) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ERR: begin
                tx_err  = 1'b1;
                drv_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                drv_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
    assign ps2_data_oe = drv_q;

endmodule
